int_mul_add: RTL and testbench

//  Iterative shift-add multiply-accumulate. Computes y = q*b + r, the inverse of the integer divider
//  (a = q*b + r). Same start/busy/ready/count handshake as the divider.

---
 rtl/int_alu_pkg.sv | 14 +
 rtl/int_mul_add.sv | 112 +++++++++++
 tb/tb_int_mul_add.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_alu_pkg.sv
// Shared widths and state encoding for the iterative integer ALU blocks
// (divider and multiply-accumulate).
package int_alu_pkg;

    localparam int WQ_DEF = 32;
    localparam int WB_DEF = 16;

    // busy is the state bit itself
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/int_mul_add.sv
// Iterative shift-add multiply-accumulate: y = q*b + r over WB iterations.
// Optional overflow flag (y exceeds WQ bits) when MULADD_OVF_EN is defined.
module int_mul_add
    import int_alu_pkg::*;
#(
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF,
    localparam int WC = $clog2(WB)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [WQ-1:0]      q,
    input  logic [WB-1:0]      b,
    input  logic [WB-1:0]      r,
    output logic [WQ+WB-1:0]   y,
    output logic               busy,
    output logic               ready,
    output logic [WC-1:0]      count
`ifdef MULADD_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int W = WQ + WB;
    localparam logic [WC-1:0] LAST = WC'(WB - 1);

    // Handshake: an edge with start=1 and busy=0 accepts the operands; start
    // is ignored while busy; ready pulses for one cycle when y is updated, and
    // a start in that same cycle is accepted (back-to-back).

    state_t          state;
    state_t          state_next;
    logic [WC-1:0]   count_next;
    logic            ready_next;

    logic [W-1:0]    acc;
    logic [W-1:0]    mc;
    logic [WB-1:0]   mp;
    logic [W-1:0]    acc_step;
    logic            accept;
    logic            last;

    assign busy     = (state == RUN);
    assign accept   = (state == IDLE) && start;
    assign last     = (state == RUN) && (count == LAST);
    assign acc_step = mp[0] ? (acc + mc) : acc;

    always_comb begin
        state_next = state;
        count_next = count;
        ready_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = '0;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            ready <= ready_next;
        end
    end

    // Datapath is wide enough that q*b+r never wraps.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            mc  <= '0;
            mp  <= '0;
            y   <= '0;
`ifdef MULADD_OVF_EN
            ovf <= 1'b0;
`endif
        end else if (accept) begin
            acc <= {{WQ{1'b0}}, r};
            mc  <= {{WB{1'b0}}, q};
            mp  <= b;
        end else if (state == RUN) begin
            acc <= acc_step;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            if (last) begin
                y   <= acc_step;
`ifdef MULADD_OVF_EN
                ovf <= |acc_step[W-1:WQ];
`endif
            end
        end
    end

endmodule

// File: tb/tb_int_mul_add.sv
// Self-checking bench for int_mul_add: directed vectors, randomized operands
// against an arithmetic reference, handshake corner cases and async reset.
module tb_int_mul_add;

    localparam int WQ = 32;
    localparam int WB = 16;
    localparam int WC = $clog2(WB);
    localparam int W  = WQ + WB;
    localparam int LAT = WB + 1;
    localparam int MAX_WAIT = 60;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic [WQ-1:0]  q = '0;
    logic [WB-1:0]  b = '0;
    logic [WB-1:0]  r = '0;
    logic [W-1:0]   y;
    logic           busy;
    logic           ready;
    logic [WC-1:0]  count;
`ifdef MULADD_OVF_EN
    logic           ovf;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    always #5 clock = ~clock;

    int_mul_add #(.WQ(WQ), .WB(WB)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .q      (q),
        .b      (b),
        .r      (r),
        .y      (y),
        .busy   (busy),
        .ready  (ready),
        .count  (count)
`ifdef MULADD_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Reference: plain arithmetic on wide integers
    function automatic logic [W-1:0] model_y(input logic [WQ-1:0] qq,
                                             input logic [WB-1:0] bb,
                                             input logic [WB-1:0] rr);
        logic [63:0] p;
        p = 64'(qq) * 64'(bb) + 64'(rr);
        return p[W-1:0];
    endfunction

    // Issue one operation and wait for ready; lat counts edges from accept
    task automatic run_op(input logic [WQ-1:0] qq, input logic [WB-1:0] bb,
                          input logic [WB-1:0] rr,
                          output logic [W-1:0] got, output int lat);
        @(negedge clock);
        q = qq; b = bb; r = rr; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!ready && lat < MAX_WAIT) begin
            @(negedge clock);
            lat++;
        end
        got = y;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (y !== '0 || busy !== 1'b0 || ready !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL reset_state: y=%h busy=%b ready=%b count=%0d, want all zero",
                     y, busy, ready, count);
        end
`ifdef MULADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [WQ-1:0] tq[3];
        logic [WB-1:0] tb[3];
        logic [WB-1:0] tr[3];
        logic [W-1:0]  ty[3];
        logic [W-1:0]  got;
        int lat;
        tq[0] = 32'h0000B8A6; tb[0] = 16'h6A0E; tr[0] = 16'h4D76; ty[0] = 48'h0000_4C7F228A;
        tq[1] = 32'hFFFFFFFF; tb[1] = 16'hFFFF; tr[1] = 16'hFFFF; ty[1] = 48'hFFFF_0000_0000;
        tq[2] = 32'h12345678; tb[2] = 16'h0000; tr[2] = 16'h00AB; ty[2] = 48'h0000_000000AB;
        for (int i = 0; i < 3; i++) begin
            run_op(tq[i], tb[i], tr[i], got, lat);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (got !== ty[i]) begin
                failures++;
                $display("FAIL directed%0d_y: got %h want %h", i, got, ty[i]);
            end
`ifdef MULADD_OVF_EN
            checks++;
            if (ovf !== (i == 1)) begin
                failures++;
                $display("FAIL directed%0d_ovf: got %b want %b", i, ovf, (i == 1));
            end
`endif
            @(negedge clock);
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || count !== WC'(WB - 1) || y !== ty[i]) begin
                failures++;
                $display("FAIL directed%0d_idle_hold: ready=%b busy=%b count=%0d y=%h want 0 0 %0d %h",
                         i, ready, busy, count, y, WB - 1, ty[i]);
            end
        end
    endtask

    task automatic test_count();
        @(negedge clock);
        q = 32'h12345678; b = 16'h0000; r = 16'h00AB; start = 1'b1;
        for (int j = 0; j < WB; j++) begin
            @(negedge clock);
            start = 1'b0;
            checks++;
            if (count !== WC'(j) || busy !== 1'b1 || ready !== 1'b0) begin
                failures++;
                $display("FAIL count_step%0d: count=%0d busy=%b ready=%b want %0d 1 0",
                         j, count, busy, ready, j);
            end
        end
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || y !== 48'h0000_000000AB) begin
            failures++;
            $display("FAIL count_final: ready=%b y=%h want 1 0000000000ab", ready, y);
        end
    endtask

    task automatic test_random();
        logic [WQ-1:0] qq;
        logic [WB-1:0] bb;
        logic [WB-1:0] rr;
        logic [W-1:0]  got;
        logic [W-1:0]  want;
        int lat;
        for (int i = 0; i < 24; i++) begin
            qq = $urandom;
            bb = WB'($urandom);
            rr = WB'($urandom);
            case ($urandom_range(0, 3))
                0: bb = '0;
                1: qq = '0;
                default: ;
            endcase
            want = model_y(qq, bb, rr);
            run_op(qq, bb, rr, got, lat);
            checks++;
            if (lat !== LAT || got !== want) begin
                failures++;
                $display("FAIL random%0d: q=%h b=%h r=%h y=%h lat=%0d want y=%h lat=%0d",
                         i, qq, bb, rr, got, lat, want, LAT);
            end
`ifdef MULADD_OVF_EN
            checks++;
            if (ovf !== (want[W-1:WQ] != '0)) begin
                failures++;
                $display("FAIL random%0d_ovf: got %b want %b", i, ovf, (want[W-1:WQ] != '0));
            end
`endif
        end
    endtask

    task automatic test_ignore_start();
        logic [WQ-1:0] qa;
        logic [WB-1:0] ba;
        logic [WB-1:0] ra;
        logic [WQ-1:0] qc;
        logic [WB-1:0] bc;
        logic [WB-1:0] rc;
        int n;
        qa = $urandom; ba = WB'($urandom); ra = WB'($urandom);
        qc = $urandom; bc = WB'($urandom); rc = WB'($urandom);
        @(negedge clock);
        q = qa; b = ba; r = ra; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (count != WC'(5) && n < MAX_WAIT) begin
            @(negedge clock);
            n++;
        end
        q = ~qa; b = ~ba; r = ~ra; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!ready && n < MAX_WAIT) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (ready !== 1'b1 || y !== model_y(qa, ba, ra)) begin
            failures++;
            $display("FAIL ignore_busy_start: ready=%b y=%h want 1 %h", ready, y, model_y(qa, ba, ra));
        end
        // Start in the ready cycle itself
        q = qc; b = bc; r = rc; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (!ready && n < MAX_WAIT) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== LAT || y !== model_y(qc, bc, rc)) begin
            failures++;
            $display("FAIL ready_cycle_start: lat=%0d y=%h want %0d %h", n, y, LAT, model_y(qc, bc, rc));
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        logic [WQ-1:0] qq;
        logic [WB-1:0] bb;
        logic [WB-1:0] rr;
        int n;
        int pulses;
        @(negedge clock);
        q = 32'hDEADBEEF; b = 16'h1234; r = 16'h5678; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (count != WC'(8) && n < MAX_WAIT) begin
            @(negedge clock);
            n++;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (y !== '0 || busy !== 1'b0 || ready !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL reset_mid: y=%h busy=%b ready=%b count=%0d want all zero",
                     y, busy, ready, count);
        end
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (i == 1) resetn = 1'b1;
            if (ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_ready: got %0d ready pulses want 0", pulses);
        end
        qq = $urandom; bb = WB'($urandom); rr = WB'($urandom);
        run_op(qq, bb, rr, got, n);
        checks++;
        if (n !== LAT || got !== model_y(qq, bb, rr)) begin
            failures++;
            $display("FAIL reset_mid_recover: y=%h lat=%0d want %h %0d", got, n, model_y(qq, bb, rr), LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want;
        int n;
        @(negedge clock);
        q = $urandom; b = WB'($urandom); r = WB'($urandom);
        exp_q.push_back(model_y(q, b, r));
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!ready && n < MAX_WAIT);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (n !== LAT || y !== want) begin
                failures++;
                $display("FAIL back_to_back%0d: lat=%0d y=%h want %0d %h", i, n, y, LAT, want);
            end
            if (i < 3) begin
                q = $urandom; b = WB'($urandom); r = WB'($urandom);
                exp_q.push_back(model_y(q, b, r));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_count();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
